// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection and
// saturating stall/flush performance counters.
module id_ex_hazard_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ID_Valid_i,
    input  logic [REG_W-1:0]  ID_RS1_i,
    input  logic [REG_W-1:0]  ID_RS2_i,
    input  logic              ID_UsesRS1_i,
    input  logic              ID_UsesRS2_i,
    input  logic [REG_W-1:0]  ID_Rd_i,
    input  logic              ID_RegWrite_i,
    input  logic              ID_MemRead_i,
    input  logic              ID_MemWrite_i,
    input  logic              ID_MemtoReg_i,
    input  logic [1:0]        ID_ALUOp_i,
    input  logic              ID_ALUSrc_i,
    input  logic [DATA_W-1:0] ID_RS1data_i,
    input  logic [DATA_W-1:0] ID_RS2data_i,
    input  logic [DATA_W-1:0] ID_Imm_i,
    input  logic [9:0]        ID_Funct_i,
    input  logic              Flush_i,
    output logic              Stall_o,
    output logic              EX_Valid_o,
    output logic [REG_W-1:0]  EX_RS1_o,
    output logic [REG_W-1:0]  EX_RS2_o,
    output logic [REG_W-1:0]  EX_Rd_o,
    output logic              EX_RegWrite_o,
    output logic              EX_MemRead_o,
    output logic              EX_MemWrite_o,
    output logic              EX_MemtoReg_o,
    output logic              EX_ALUSrc_o,
    output logic [1:0]        EX_ALUOp_o,
    output logic [DATA_W-1:0] EX_RS1data_o,
    output logic [DATA_W-1:0] EX_RS2data_o,
    output logic [DATA_W-1:0] EX_Imm_o,
    output logic [9:0]        EX_Funct_o,
    output logic [CNT_W-1:0]  StallCnt_o,
    output logic [CNT_W-1:0]  FlushCnt_o
);

    logic rs1_match;
    logic rs2_match;
    logic take_id;

    always_comb begin
        rs1_match = ID_UsesRS1_i && (ID_RS1_i == EX_Rd_o);
        rs2_match = ID_UsesRS2_i && (ID_RS2_i == EX_Rd_o);
        Stall_o   = EX_Valid_o && EX_MemRead_o && (EX_Rd_o != '0) &&
                    ID_Valid_i && !Flush_i && (rs1_match || rs2_match);
        take_id   = !Flush_i && !Stall_o;
    end

    // Flush and stall both load a bubble: every field is zeroed unless ID is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            EX_Valid_o    <= 1'b0;
            EX_RS1_o      <= '0;
            EX_RS2_o      <= '0;
            EX_Rd_o       <= '0;
            EX_RegWrite_o <= 1'b0;
            EX_MemRead_o  <= 1'b0;
            EX_MemWrite_o <= 1'b0;
            EX_MemtoReg_o <= 1'b0;
            EX_ALUSrc_o   <= 1'b0;
            EX_ALUOp_o    <= '0;
            EX_RS1data_o  <= '0;
            EX_RS2data_o  <= '0;
            EX_Imm_o      <= '0;
            EX_Funct_o    <= '0;
            StallCnt_o    <= '0;
            FlushCnt_o    <= '0;
        end else begin
            EX_Valid_o    <= take_id && ID_Valid_i;
            EX_RS1_o      <= take_id ? ID_RS1_i      : '0;
            EX_RS2_o      <= take_id ? ID_RS2_i      : '0;
            EX_Rd_o       <= take_id ? ID_Rd_i       : '0;
            EX_RegWrite_o <= take_id && ID_RegWrite_i;
            EX_MemRead_o  <= take_id && ID_MemRead_i;
            EX_MemWrite_o <= take_id && ID_MemWrite_i;
            EX_MemtoReg_o <= take_id && ID_MemtoReg_i;
            EX_ALUSrc_o   <= take_id && ID_ALUSrc_i;
            EX_ALUOp_o    <= take_id ? ID_ALUOp_i    : '0;
            EX_RS1data_o  <= take_id ? ID_RS1data_i  : '0;
            EX_RS2data_o  <= take_id ? ID_RS2data_i  : '0;
            EX_Imm_o      <= take_id ? ID_Imm_i      : '0;
            EX_Funct_o    <= take_id ? ID_Funct_i    : '0;

            if (Flush_i && ID_Valid_i && (FlushCnt_o != '1))
                FlushCnt_o <= FlushCnt_o + CNT_W'(1);
            if (Stall_o && (StallCnt_o != '1))
                StallCnt_o <= StallCnt_o + CNT_W'(1);
        end
    end

endmodule
